// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared state encoding, length codes and index-width helper
// for the memory-port arbiter.
package mem_arbiter_pkg;

   typedef enum logic [1:0] {
      MEM_ARB_IDLE = 2'd0,
      MEM_ARB_BUSY = 2'd1,
      MEM_ARB_RESP = 2'd2
   } arb_state_t;

   // Default access-length codes carried on *_len / m_len
   localparam logic [1:0] LEN_BYTE = 2'd0;
   localparam logic [1:0] LEN_HALF = 2'd1;
   localparam logic [1:0] LEN_WORD = 2'd2;

   // Width of an index into n requesters (at least one bit)
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/mem_arbiter_rr_picker.sv
// mem_arbiter_rr_picker: combinational round-robin picker. Returns the first
// requester at or after i_ptr (cyclic) as a one-hot grant plus its index.
module mem_arbiter_rr_picker #(
   parameter int N  = 3,
   parameter int IW = 2
) (
   input  logic [N-1:0]  i_req,
   input  logic [IW-1:0] i_ptr,
   output logic [N-1:0]  o_gnt,
   output logic [IW-1:0] o_idx,
   output logic          o_any
);

   // Scan N positions starting at the pointer, first hit wins
   always_comb begin
      int j;
      j     = 0;
      o_gnt = '0;
      o_idx = '0;
      o_any = 1'b0;
      for (int k = 0; k < N; k++) begin
         j = int'(i_ptr) + k;
         if (j >= N) j = j - N;
         if (!o_any && i_req[j]) begin
            o_any    = 1'b1;
            o_gnt[j] = 1'b1;
            o_idx    = IW'(j);
         end
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter from R_PORT read and W_PORT write requesters
// onto a single memory port. Reads occupy indices 0..R_PORT-1, writes follow.
// Optional build macro MEM_ARB_WR_PRIO_EN: pending writes beat all reads.
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int R_PORT = 2,
   parameter int W_PORT = 1,
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int LEN_W  = 2,
   localparam int WP    = (W_PORT > 0) ? W_PORT : 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [R_PORT-1:0]        co_re,
   input  logic [R_PORT*ADDR_W-1:0] co_raddr,
   input  logic [R_PORT*LEN_W-1:0]  co_rlen,
   output logic [R_PORT*DATA_W-1:0] co_rdata,
   output logic [R_PORT-1:0]        co_rack,
   input  logic [WP-1:0]            co_we,
   input  logic [WP*ADDR_W-1:0]     co_waddr,
   input  logic [WP*LEN_W-1:0]      co_wlen,
   input  logic [WP*DATA_W-1:0]     co_wdata,
   output logic [WP-1:0]            co_wack,
   output logic                     m_re,
   output logic                     m_we,
   output logic [ADDR_W-1:0]        m_addr,
   output logic [LEN_W-1:0]         m_len,
   output logic [DATA_W-1:0]        m_wdata,
   input  logic [DATA_W-1:0]        m_rdata,
   input  logic                     m_ack
);

   localparam int N  = R_PORT + W_PORT;
   localparam int IW = idx_w(N);

   arb_state_t                r_state, w_state_nxt;
   logic [IW-1:0]             r_ptr, r_win;
   logic                      r_is_wr, r_re, r_we;
   logic [ADDR_W-1:0]         r_addr;
   logic [LEN_W-1:0]          r_len;
   logic [DATA_W-1:0]         r_wdata;
   logic [R_PORT*DATA_W-1:0]  r_rdata;
   logic [R_PORT-1:0]         r_rack;
   logic [WP-1:0]             r_wack;

   logic [N-1:0]              w_req, w_gnt;
   logic [IW-1:0]             w_win;
   logic                      w_any, w_is_wr;
   logic [ADDR_W-1:0]         w_sel_addr;
   logic [LEN_W-1:0]          w_sel_len;
   logic [DATA_W-1:0]         w_sel_wdata;

   generate
      if (W_PORT > 0) begin : g_req_wr
         assign w_req = {co_we, co_re};
      end else begin : g_req_rd
         assign w_req = co_re;
      end
   endgenerate

`ifdef MEM_ARB_WR_PRIO_EN
   // Reads and writes picked separately; any write request wins the slot.
   // Each picker starts at rr_ptr when it points into its own group.
   logic [R_PORT-1:0] w_rgnt;
   logic [IW-1:0]     w_ridx, w_rptr;
   logic              w_rany;

   assign w_rptr = (int'(r_ptr) < R_PORT) ? r_ptr : '0;

   mem_arbiter_rr_picker #(.N(R_PORT), .IW(IW)) u_rd_pick (
      .i_req (w_req[R_PORT-1:0]),
      .i_ptr (w_rptr),
      .o_gnt (w_rgnt),
      .o_idx (w_ridx),
      .o_any (w_rany)
   );

   generate
      if (W_PORT > 0) begin : g_wr_pick
         logic [W_PORT-1:0] w_wgnt;
         logic [IW-1:0]     w_widx, w_wptr;
         logic              w_wany;

         assign w_wptr = (int'(r_ptr) >= R_PORT) ? IW'(int'(r_ptr) - R_PORT) : '0;

         mem_arbiter_rr_picker #(.N(W_PORT), .IW(IW)) u_wr_pick (
            .i_req (w_req[N-1:R_PORT]),
            .i_ptr (w_wptr),
            .o_gnt (w_wgnt),
            .o_idx (w_widx),
            .o_any (w_wany)
         );

         assign w_any   = w_wany | w_rany;
         assign w_is_wr = w_wany;
         assign w_gnt   = w_wany ? {w_wgnt, {R_PORT{1'b0}}} : {{W_PORT{1'b0}}, w_rgnt};
         assign w_win   = w_wany ? IW'(int'(w_widx) + R_PORT) : w_ridx;
      end else begin : g_no_wr_pick
         assign w_any   = w_rany;
         assign w_is_wr = 1'b0;
         assign w_gnt   = w_rgnt;
         assign w_win   = w_ridx;
      end
   endgenerate
`else
   // Single round-robin over all requesters
   mem_arbiter_rr_picker #(.N(N), .IW(IW)) u_pick (
      .i_req (w_req),
      .i_ptr (r_ptr),
      .o_gnt (w_gnt),
      .o_idx (w_win),
      .o_any (w_any)
   );
   assign w_is_wr = (int'(w_win) >= R_PORT);
`endif

   // Route the granted requester's address, length and write data
   always_comb begin
      w_sel_addr  = '0;
      w_sel_len   = '0;
      w_sel_wdata = '0;
      for (int i = 0; i < R_PORT; i++) begin
         if (w_gnt[i]) begin
            w_sel_addr = co_raddr[i*ADDR_W +: ADDR_W];
            w_sel_len  = co_rlen[i*LEN_W +: LEN_W];
         end
      end
      for (int i = 0; i < W_PORT; i++) begin
         if (w_gnt[R_PORT+i]) begin
            w_sel_addr  = co_waddr[i*ADDR_W +: ADDR_W];
            w_sel_len   = co_wlen[i*LEN_W +: LEN_W];
            w_sel_wdata = co_wdata[i*DATA_W +: DATA_W];
         end
      end
   end

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_state <= MEM_ARB_IDLE;
      else      r_state <= w_state_nxt;
   end

   // Next state: issue on any request, wait for memory, one dead cycle
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         MEM_ARB_IDLE: if (w_any) w_state_nxt = MEM_ARB_BUSY;
         MEM_ARB_BUSY: if (m_ack) w_state_nxt = MEM_ARB_RESP;
         MEM_ARB_RESP: w_state_nxt = MEM_ARB_IDLE;
         default:      w_state_nxt = MEM_ARB_IDLE;
      endcase
   end

   // Memory-side registers, read data return, acks and rr pointer
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_ptr   <= '0;
         r_win   <= '0;
         r_is_wr <= 1'b0;
         r_re    <= 1'b0;
         r_we    <= 1'b0;
         r_addr  <= '0;
         r_len   <= '0;
         r_wdata <= '0;
         r_rdata <= '0;
         r_rack  <= '0;
         r_wack  <= '0;
      end else begin
         r_rack <= '0;
         r_wack <= '0;
         case (r_state)
            MEM_ARB_IDLE: begin
               if (w_any) begin
                  r_win   <= w_win;
                  r_is_wr <= w_is_wr;
                  r_re    <= !w_is_wr;
                  r_we    <= w_is_wr;
                  r_addr  <= w_sel_addr;
                  r_len   <= w_sel_len;
                  r_wdata <= w_sel_wdata;
               end
            end
            MEM_ARB_BUSY: begin
               if (m_ack) begin
                  r_re  <= 1'b0;
                  r_we  <= 1'b0;
                  r_ptr <= (int'(r_win) == N - 1) ? '0 : r_win + IW'(1);
                  for (int i = 0; i < R_PORT; i++) begin
                     if (!r_is_wr && int'(r_win) == i) begin
                        r_rdata[i*DATA_W +: DATA_W] <= m_rdata;
                        r_rack[i]                   <= 1'b1;
                     end
                  end
                  for (int i = 0; i < W_PORT; i++) begin
                     if (r_is_wr && int'(r_win) == R_PORT + i) r_wack[i] <= 1'b1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   assign m_re     = r_re;
   assign m_we     = r_we;
   assign m_addr   = r_addr;
   assign m_len    = r_len;
   assign m_wdata  = r_wdata;
   assign co_rdata = r_rdata;
   assign co_rack  = r_rack;
   assign co_wack  = r_wack;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenarios plus a randomized run checked against a
// transaction-level model of the arbiter (2 read ports, 1 write port).
module tb_mem_arbiter;

   localparam int R  = 2;
   localparam int W  = 1;
   localparam int NP = R + W;

   logic          clk = 1'b0;
   logic          rst;
   logic [R-1:0]  co_re;
   logic [R*32-1:0] co_raddr;
   logic [R*2-1:0]  co_rlen;
   logic [R*32-1:0] co_rdata;
   logic [R-1:0]  co_rack;
   logic [W-1:0]  co_we;
   logic [W*32-1:0] co_waddr;
   logic [W*2-1:0]  co_wlen;
   logic [W*32-1:0] co_wdata;
   logic [W-1:0]  co_wack;
   logic          m_re, m_we;
   logic [31:0]   m_addr;
   logic [1:0]    m_len;
   logic [31:0]   m_wdata;
   logic [31:0]   m_rdata;
   logic          m_ack;

   int vectors    = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   mem_arbiter #(.R_PORT(R), .W_PORT(W), .ADDR_W(32), .DATA_W(32), .LEN_W(2)) dut (
      .clk(clk), .rst(rst),
      .co_re(co_re), .co_raddr(co_raddr), .co_rlen(co_rlen),
      .co_rdata(co_rdata), .co_rack(co_rack),
      .co_we(co_we), .co_waddr(co_waddr), .co_wlen(co_wlen), .co_wdata(co_wdata),
      .co_wack(co_wack),
      .m_re(m_re), .m_we(m_we), .m_addr(m_addr), .m_len(m_len), .m_wdata(m_wdata),
      .m_rdata(m_rdata), .m_ack(m_ack)
   );

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      co_re = '0; co_raddr = '0; co_rlen = '0;
      co_we = '0; co_waddr = '0; co_wlen = '0; co_wdata = '0;
      m_rdata = '0; m_ack = 1'b0;
      rst = 1'b0;
      tick();
      rst = 1'b1;
   endtask

   // Reference pick: first requester in cyclic order from ptr; with write
   // priority, only write requesters are eligible when any is present.
   function automatic int model_pick(input logic [NP-1:0] req, input int ptr);
      logic [NP-1:0] r;
      int q;
      r = req;
`ifdef MEM_ARB_WR_PRIO_EN
      if (req[NP-1:R] != '0) r = req & ~(NP'((1 << R) - 1));
`endif
      for (int k = 0; k < NP; k++) begin
         q = (ptr + k) % NP;
         if (r[q]) return q;
      end
      return -1;
   endfunction

   task automatic test_reset();
      rst = 1'b0;
      co_re = '0; co_we = '0; m_ack = 1'b0;
      co_raddr = '0; co_rlen = '0; co_waddr = '0; co_wlen = '0; co_wdata = '0; m_rdata = '0;
      #1;
      vectors++;
      if ({m_re, m_we, m_addr, m_len, m_wdata, co_rdata, co_rack, co_wack} !== '0) begin
         miscompares++;
         $display("FAIL reset_outputs: got re=%b we=%b addr=%h rdata=%h, want all zero", m_re, m_we, m_addr, co_rdata);
      end
      do_reset();
      // load port 1 read data so the mid-BUSY reset has something to clear
      co_re = 2'b10; co_raddr[63:32] = 32'h40;
      tick();
      tick();
      m_ack = 1'b1; m_rdata = 32'hA5A5_0001;
      tick();
      m_ack = 1'b0; co_re = '0;
      tick();
      tick();
      // port 0 read, reset while BUSY
      co_re = 2'b01; co_raddr[31:0] = 32'h80;
      tick();
      vectors++;
      if (m_re !== 1'b1) begin
         miscompares++;
         $display("FAIL reset_pre_busy: got m_re=%b, want 1", m_re);
      end
      #2 rst = 1'b0;
      #1;
      vectors++;
      if (m_re !== 1'b0 || co_rdata !== '0 || co_rack !== '0) begin
         miscompares++;
         $display("FAIL reset_mid_busy: got m_re=%b rdata=%h rack=%b, want 0/0/0", m_re, co_rdata, co_rack);
      end
      @(negedge clk);
      rst = 1'b1;
      co_re = 2'b11; co_raddr = {32'hB0, 32'hA0};
      tick();
      vectors++;
      if (m_re !== 1'b1 || m_addr !== 32'hA0) begin
         miscompares++;
         $display("FAIL reset_first_grant: got m_re=%b addr=%h, want 1 a0", m_re, m_addr);
      end
   endtask

   task automatic test_single_read();
      int hi;
      do_reset();
      hi = 0;
      co_re = 2'b01; co_raddr[31:0] = 32'h100; co_rlen[1:0] = 2'd2;
      tick();
      if (m_re) hi++;
      vectors++;
      if (m_addr !== 32'h100 || m_len !== 2'd2 || m_we !== 1'b0) begin
         miscompares++;
         $display("FAIL read_issue: got addr=%h len=%0d we=%b, want 100 2 0", m_addr, m_len, m_we);
      end
      tick();
      if (m_re) hi++;
      m_ack = 1'b1; m_rdata = 32'hDEAD_BEEF;
      tick();
      if (m_re) hi++;
      m_ack = 1'b0; co_re = '0; m_rdata = '0;
      vectors++;
      if (co_rack !== 2'b01 || co_rdata[31:0] !== 32'hDEAD_BEEF || co_wack !== '0) begin
         miscompares++;
         $display("FAIL read_ack: got rack=%b rdata=%h, want 01 deadbeef", co_rack, co_rdata[31:0]);
      end
      tick();
      if (m_re) hi++;
      vectors++;
      if (co_rack !== 2'b00 || co_rdata[31:0] !== 32'hDEAD_BEEF) begin
         miscompares++;
         $display("FAIL read_ack_pulse: got rack=%b rdata=%h, want 00 deadbeef", co_rack, co_rdata[31:0]);
      end
      vectors++;
      if (hi != 2) begin
         miscompares++;
         $display("FAIL read_strobe_len: got %0d cycles, want 2", hi);
      end
   endtask

   task automatic test_round_robin();
      int w, got;
      do_reset();
      co_raddr = {32'h1001, 32'h1000}; co_waddr = 32'h1002; co_wdata = 32'h55;
      co_re = 2'b11; co_we = 1'b1;
      for (int i = 0; i < 6; i++) begin
         w = 0;
         while (!(m_re || m_we) && w < 8) begin
            tick();
            w++;
         end
         got = int'(m_addr) - 32'h1000;
         vectors++;
         if (got != i % NP || w != ((i == 0) ? 1 : 2)) begin
            miscompares++;
            $display("FAIL rr_grant%0d: got port %0d after %0d cycles, want port %0d", i, got, w, i % NP);
         end
         tick();
         m_ack = 1'b1;
         tick();
         m_ack = 1'b0;
         vectors++;
         if ({co_wack, co_rack} !== NP'(1 << (i % NP))) begin
            miscompares++;
            $display("FAIL rr_ack%0d: got %b, want %b", i, {co_wack, co_rack}, NP'(1 << (i % NP)));
         end
      end
      co_re = '0; co_we = '0;
      tick();
   endtask

   task automatic test_write();
      do_reset();
      co_we = 1'b1; co_waddr = 32'h200; co_wdata = 32'h1234_5678; co_wlen = 2'd2;
      for (int c = 0; c < 3; c++) begin
         tick();
         vectors++;
         if (m_we !== 1'b1 || m_re !== 1'b0 || m_addr !== 32'h200 || m_wdata !== 32'h1234_5678 || m_len !== 2'd2) begin
            miscompares++;
            $display("FAIL write_hold%0d: got we=%b re=%b addr=%h wdata=%h len=%0d", c, m_we, m_re, m_addr, m_wdata, m_len);
         end
      end
      m_ack = 1'b1;
      tick();
      m_ack = 1'b0; co_we = '0;
      vectors++;
      if (co_wack !== 1'b1 || m_we !== 1'b0 || co_rack !== '0) begin
         miscompares++;
         $display("FAIL write_ack: got wack=%b we=%b rack=%b, want 1 0 00", co_wack, m_we, co_rack);
      end
      tick();
      vectors++;
      if (co_wack !== 1'b0) begin
         miscompares++;
         $display("FAIL write_ack_pulse: got wack=%b, want 0", co_wack);
      end
   endtask

   task automatic test_priority();
      logic exp_we;
`ifdef MEM_ARB_WR_PRIO_EN
      exp_we = 1'b1;
`else
      exp_we = 1'b0;
`endif
      do_reset();
      co_re = 2'b01; co_raddr[31:0] = 32'h300; co_we = 1'b1; co_waddr = 32'h400;
      tick();
      vectors++;
      if (m_we !== exp_we || m_re !== !exp_we || m_addr !== (exp_we ? 32'h400 : 32'h300)) begin
         miscompares++;
         $display("FAIL priority: got re=%b we=%b addr=%h, want we=%b", m_re, m_we, m_addr, exp_we);
      end
      co_re = '0; co_we = '0;
      m_ack = 1'b1;
      tick();
      m_ack = 1'b0;
      tick();
   endtask

   task automatic test_stray_ack();
      do_reset();
      m_ack = 1'b1;
      tick();
      m_ack = 1'b0;
      vectors++;
      if ({co_rack, co_wack, m_re, m_we} !== '0) begin
         miscompares++;
         $display("FAIL stray_ack: got rack=%b wack=%b re=%b we=%b, want zeros", co_rack, co_wack, m_re, m_we);
      end
      co_re = 2'b10; co_raddr[63:32] = 32'h600;
      tick();
      vectors++;
      if (m_re !== 1'b1 || m_addr !== 32'h600) begin
         miscompares++;
         $display("FAIL stray_ack_idle: got re=%b addr=%h, want 1 600", m_re, m_addr);
      end
      co_re = '0;
      m_ack = 1'b1;
      tick();
      m_ack = 1'b0;
      tick();
   endtask

   task automatic new_attr(input int p);
      if (p < R) begin
         co_raddr[p*32 +: 32] = $urandom;
         co_rlen[p*2 +: 2]    = 2'($urandom_range(0, 2));
      end else begin
         co_waddr[(p-R)*32 +: 32] = $urandom;
         co_wlen[(p-R)*2 +: 2]    = 2'($urandom_range(0, 2));
         co_wdata[(p-R)*32 +: 32] = $urandom;
      end
   endtask

   task automatic test_random(input int ncyc);
      int mptr, win, idle_at;
      bit outst;
      logic [NP-1:0] req, held, exp_ack;
      logic mack;
      logic [31:0] rdat, exp_addr, exp_wdata;
      logic [1:0] exp_len;
      logic [R*32-1:0] exp_rd;
      logic exp_re, exp_we;
      do_reset();
      mptr = 0; win = 0; idle_at = 0; outst = 0; held = '0;
      exp_rd = '0; exp_addr = '0; exp_wdata = '0; exp_len = '0;
      for (int e = 0; e < ncyc; e++) begin
         req = {co_we, co_re}; mack = m_ack; rdat = m_rdata;
         tick();
         exp_ack = '0; exp_re = 1'b0; exp_we = 1'b0;
         if (outst) begin
            if (mack) begin
               exp_ack[win] = 1'b1;
               if (win < R) exp_rd[win*32 +: 32] = rdat;
               mptr = (win + 1) % NP;
               outst = 0;
               idle_at = e + 2;
            end else begin
               exp_re = (win < R); exp_we = (win >= R);
            end
         end else if (e >= idle_at && req != '0) begin
            win = model_pick(req, mptr);
            outst = 1;
            exp_re = (win < R); exp_we = (win >= R);
            if (win < R) begin
               exp_addr = co_raddr[win*32 +: 32]; exp_len = co_rlen[win*2 +: 2];
            end else begin
               exp_addr = co_waddr[(win-R)*32 +: 32]; exp_len = co_wlen[(win-R)*2 +: 2];
               exp_wdata = co_wdata[(win-R)*32 +: 32];
            end
         end
         vectors++;
         if (m_re !== exp_re || m_we !== exp_we || {co_wack, co_rack} !== exp_ack || co_rdata !== exp_rd) begin
            miscompares++;
            $display("FAIL rand_c%0d: got re=%b we=%b ack=%b rdata=%h, want re=%b we=%b ack=%b rdata=%h",
                     e, m_re, m_we, {co_wack, co_rack}, co_rdata, exp_re, exp_we, exp_ack, exp_rd);
         end
         if (exp_re || exp_we) begin
            vectors++;
            if (m_addr !== exp_addr || m_len !== exp_len || (exp_we && m_wdata !== exp_wdata)) begin
               miscompares++;
               $display("FAIL rand_attr_c%0d: got addr=%h len=%0d wdata=%h, want addr=%h len=%0d wdata=%h",
                        e, m_addr, m_len, m_wdata, exp_addr, exp_len, exp_wdata);
            end
         end
         // next requester behaviour: hold until acked, then drop or reissue
         for (int p = 0; p < NP; p++) begin
            if (held[p]) begin
               if (exp_ack[p]) begin
                  if ($urandom_range(0, 1) == 0) held[p] = 1'b0;
                  else new_attr(p);
               end
            end else if ($urandom_range(0, 3) == 0) begin
               held[p] = 1'b1;
               new_attr(p);
            end
         end
         co_re = held[R-1:0]; co_we = held[NP-1:R];
         m_rdata = $urandom;
         if (outst) m_ack = ($urandom_range(0, 1) == 1);
         else       m_ack = ($urandom_range(0, 7) == 0);
      end
      co_re = '0; co_we = '0; m_ack = 1'b0;
   endtask

   initial begin
      test_reset();
      test_single_read();
      test_round_robin();
      test_write();
      test_priority();
      test_stray_ack();
      test_random(3000);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
